// File: rtl/gdm_instr_mem.sv
// Instruction memory for the fetch interface. A byte-stream boot loader fills the RAM after reset,
// then the block serves registered fetch reads until the next reset.
module gdm_instr_mem #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_gdm_en,
  input  logic [31:0]           if_gdm_addr,
  output logic [31:0]           gdm_if_data,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_byte,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  gdm_ready,
  output logic                  gdm_addr_err,
  output logic                  gdm_ovf,
  output logic [ADDR_WIDTH:0]   gdm_words
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic {StLoad, StRun} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [31:0]             acc_q, acc_d;
  logic [31:0]             asm_word;
  logic [ADDR_WIDTH:0]     wptr_q, wptr_d;
  logic                    ovf_q, ovf_d;
  logic                    accept, word_done, mem_we;
  logic [31:0]             data_q, data_d;
  logic                    err_q, err_d;
  logic                    fetch_oor, fetch_mis;
  logic [ADDR_WIDTH-1:0]   rd_idx;

  logic [31:0] mem [Depth];

  // Incoming byte merged into the partial word; untouched low bytes stay zero, which gives the
  // zero padding of a short final word for free.
  always_comb begin
    asm_word = acc_q;
    unique case (byte_idx_q)
      2'd0: asm_word = {ld_byte, 24'h0};
      2'd1: asm_word = {acc_q[31:24], ld_byte, 16'h0};
      2'd2: asm_word = {acc_q[31:16], ld_byte, 8'h0};
      2'd3: asm_word = {acc_q[31:8], ld_byte};
      default: asm_word = acc_q;
    endcase
  end

  always_comb begin
    accept     = (state_q == StLoad) && ld_valid;
    word_done  = accept && ((byte_idx_q == 2'd3) || ld_last);
    // The MSB of wptr is set exactly when the RAM is full, as wptr saturates at Depth.
    mem_we     = word_done && !wptr_q[ADDR_WIDTH];

    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    acc_d      = acc_q;
    wptr_d     = wptr_q;
    ovf_d      = ovf_q;

    if (accept) begin
      if (word_done) begin
        byte_idx_d = 2'd0;
        acc_d      = 32'h0;
        if (mem_we) begin
          wptr_d = wptr_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
        if (ld_last) begin
          state_d = StRun;
        end
      end else begin
        byte_idx_d = byte_idx_q + 2'd1;
        acc_d      = asm_word;
      end
    end
  end

  always_comb begin
    fetch_oor = |if_gdm_addr[31:ADDR_WIDTH+2];
    fetch_mis = |if_gdm_addr[1:0];
    rd_idx    = if_gdm_addr[ADDR_WIDTH+1:2];
    data_d    = 32'h0;
    err_d     = 1'b0;
    if ((state_q == StRun) && if_gdm_en) begin
      err_d = fetch_oor || fetch_mis;
      if (!fetch_oor) begin
        data_d = mem[rd_idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StLoad;
      byte_idx_q <= 2'd0;
      acc_q      <= 32'h0;
      wptr_q     <= '0;
      ovf_q      <= 1'b0;
      data_q     <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      acc_q      <= acc_d;
      wptr_q     <= wptr_d;
      ovf_q      <= ovf_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem[wptr_q[ADDR_WIDTH-1:0]] <= asm_word;
    end
  end

  assign gdm_if_data  = data_q;
  assign gdm_addr_err = err_q;
  assign ld_ready     = (state_q == StLoad);
  assign gdm_ready    = (state_q == StRun);
  assign gdm_ovf      = ovf_q;
  assign gdm_words    = wptr_q;

endmodule

// File: tb/tb_gdm_instr_mem.sv
// Bench for gdm_instr_mem: a deep (ADDR_WIDTH=8) and a tiny (ADDR_WIDTH=2) instance, selected by
// sel, checked against a byte-list image model.
module tb_gdm_instr_mem;

  logic        clock = 1'b0;
  logic        reset, if_gdm_en, ld_valid, ld_last, sel;
  logic [31:0] if_gdm_addr;
  logic [7:0]  ld_byte;

  logic [31:0] data8, data2;
  logic        rdy8, rdy2, ldr8, ldr2, err8, err2, ovf8, ovf2;
  logic [8:0]  words8;
  logic [2:0]  words2;

  logic [31:0] o_data, o_words;
  logic        o_ready, o_ld_ready, o_err, o_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mm [2][256];
  int          mw;
  bit          movf;

  always #5 clock = ~clock;

  gdm_instr_mem #(.ADDR_WIDTH(8)) dut8 (
    .clock        (clock),
    .reset        (reset),
    .if_gdm_en    (if_gdm_en),
    .if_gdm_addr  (if_gdm_addr),
    .gdm_if_data  (data8),
    .ld_valid     (ld_valid && !sel),
    .ld_byte      (ld_byte),
    .ld_last      (ld_last),
    .ld_ready     (ldr8),
    .gdm_ready    (rdy8),
    .gdm_addr_err (err8),
    .gdm_ovf      (ovf8),
    .gdm_words    (words8)
  );

  gdm_instr_mem #(.ADDR_WIDTH(2)) dut2 (
    .clock        (clock),
    .reset        (reset),
    .if_gdm_en    (if_gdm_en),
    .if_gdm_addr  (if_gdm_addr),
    .gdm_if_data  (data2),
    .ld_valid     (ld_valid && sel),
    .ld_byte      (ld_byte),
    .ld_last      (ld_last),
    .ld_ready     (ldr2),
    .gdm_ready    (rdy2),
    .gdm_addr_err (err2),
    .gdm_ovf      (ovf2),
    .gdm_words    (words2)
  );

  assign o_data     = sel ? data2 : data8;
  assign o_ready    = sel ? rdy2 : rdy8;
  assign o_ld_ready = sel ? ldr2 : ldr8;
  assign o_err      = sel ? err2 : err8;
  assign o_ovf      = sel ? ovf2 : ovf8;
  assign o_words    = sel ? {29'h0, words2} : {23'h0, words8};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Image model: bytes grouped four at a time, big-endian, short tail zero-padded, words past
  // the RAM depth dropped and flagged.
  task automatic model_load(input bit s, input logic [7:0] b[$]);
    int depth = s ? 4 : 256;
    int nw = (b.size() + 3) / 4;
    mw   = 0;
    movf = 1'b0;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] word = 32'h0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < b.size()) word = word | (32'(b[4 * w + k]) << (24 - 8 * k));
      end
      if (mw < depth) begin
        mm[s][mw] = word;
        mw++;
      end else begin
        movf = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] exp_data(input bit s, input logic en, input logic [31:0] a);
    int aw = s ? 2 : 8;
    if (!en) return 32'h0;
    if ((a >> (aw + 2)) != 0) return 32'h0;
    return mm[s][int'((a >> 2) & ((32'h1 << aw) - 1))];
  endfunction

  function automatic logic exp_err(input bit s, input logic en, input logic [31:0] a);
    int aw = s ? 2 : 8;
    return en && (((a >> (aw + 2)) != 0) || (a[1:0] != 2'b00));
  endfunction

  // All tasks start and end at a negedge.
  task automatic do_reset();
    reset     = 1'b1;
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
    if_gdm_en = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("rst_data", o_data, 32'h0);
    check("rst_ld_ready", 32'(o_ld_ready), 32'h1);
    check("rst_ready", 32'(o_ready), 32'h0);
    check("rst_err", 32'(o_err), 32'h0);
    check("rst_ovf", 32'(o_ovf), 32'h0);
    check("rst_words", o_words, 32'h0);
    reset = 1'b0;
  endtask

  task automatic load_bytes(input logic [7:0] b[$], input bit with_last);
    for (int i = 0; i < b.size(); i++) begin
      ld_valid    = 1'b1;
      ld_byte     = b[i];
      ld_last     = with_last && (i == b.size() - 1);
      if_gdm_en   = 1'($urandom_range(0, 1));
      if_gdm_addr = $urandom & 32'h0000_03ff;
      check("load_ld_ready", 32'(o_ld_ready), 32'h1);
      check("load_data", o_data, 32'h0);
      check("load_ready", 32'(o_ready), 32'h0);
      @(posedge clock);
      @(negedge clock);
    end
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
    if_gdm_en = 1'b0;
  endtask

  task automatic check_loaded(input string tag);
    check({tag, "_ld_ready"}, 32'(o_ld_ready), 32'h0);
    check({tag, "_ready"}, 32'(o_ready), 32'h1);
    check({tag, "_words"}, o_words, 32'(mw));
    check({tag, "_ovf"}, 32'(o_ovf), 32'(movf));
  endtask

  task automatic fetch(input string tag, input logic en, input logic [31:0] addr);
    logic [31:0] ed = exp_data(sel, en, addr);
    logic        ee = exp_err(sel, en, addr);
    if_gdm_en   = en;
    if_gdm_addr = addr;
    @(posedge clock);
    @(negedge clock);
    check({tag, "_data"}, o_data, ed);
    check({tag, "_err"}, 32'(o_err), 32'(ee));
  endtask

  initial begin
    logic [7:0] q[$];
    reset       = 1'b1;
    sel         = 1'b0;
    ld_valid    = 1'b0;
    ld_last     = 1'b0;
    ld_byte     = 8'h0;
    if_gdm_en   = 1'b0;
    if_gdm_addr = 32'h0;
    @(negedge clock);

    // Load and read back, then bad-address cases.
    do_reset();
    q = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    model_load(1'b0, q);
    load_bytes(q, 1'b1);
    check_loaded("rb");
    check("rb_words_const", o_words, 32'd2);
    fetch("rb0", 1'b1, 32'h0);
    check("rb0_const", o_data, 32'h0011_2233);
    fetch("rb1", 1'b1, 32'h4);
    check("rb1_const", o_data, 32'h4455_6677);
    fetch("oor", 1'b1, 32'h400);
    check("oor_const", o_data, 32'h0);
    fetch("after_oor", 1'b1, 32'h0);
    check("err_one_cycle", 32'(o_err), 32'h0);
    fetch("mis", 1'b1, 32'h6);
    check("mis_const", o_data, 32'h4455_6677);
    fetch("dis", 1'b0, 32'h4);

    // Partial final word.
    do_reset();
    q = '{8'hAA, 8'hBB, 8'hCC};
    model_load(1'b0, q);
    load_bytes(q, 1'b1);
    check_loaded("part");
    fetch("part0", 1'b1, 32'h0);
    check("part0_const", o_data, 32'hAABB_CC00);

    // Overflow on the 4-word instance.
    sel = 1'b1;
    do_reset();
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom_range(0, 255)));
    model_load(1'b1, q);
    load_bytes(q, 1'b1);
    check_loaded("ovf");
    check("ovf_const", 32'(o_ovf), 32'h1);
    check("ovf_words_const", o_words, 32'd4);
    fetch("ovf0", 1'b1, 32'h0);
    check("ovf0_const", o_data, {q[0], q[1], q[2], q[3]});

    // Reset mid-load, with fetch requests while loading.
    sel = 1'b0;
    do_reset();
    q = '{8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96};
    load_bytes(q, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if_gdm_en   = 1'b1;
      if_gdm_addr = 32'h0;
      @(posedge clock);
      @(negedge clock);
      check("midload_data", o_data, 32'h0);
      check("midload_ready", 32'(o_ready), 32'h0);
    end
    do_reset();
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    model_load(1'b0, q);
    load_bytes(q, 1'b1);
    check_loaded("rml");
    fetch("rml0", 1'b1, 32'h0);
    check("rml0_const", o_data, 32'h0102_0304);

    // Randomized images and fetches on both instances.
    for (int it = 0; it < 6; it++) begin
      int n, nvalid, aw;
      sel = 1'($urandom_range(0, 1));
      aw  = sel ? 2 : 8;
      do_reset();
      n = sel ? $urandom_range(1, 22) : $urandom_range(1, 40);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
      model_load(sel, q);
      load_bytes(q, 1'b1);
      check_loaded("rnd");
      nvalid = mw;
      for (int f = 0; f < 10; f++) begin
        int kind = $urandom_range(0, 3);
        logic [31:0] a;
        case (kind)
          0: a = 32'($urandom_range(0, nvalid - 1) * 4);
          1: a = 32'($urandom_range(0, nvalid - 1) * 4 + $urandom_range(1, 3));
          2: a = ($urandom | 32'h8000_0000) | (32'h1 << (aw + 2));
          default: a = 32'($urandom_range(0, nvalid - 1) * 4);
        endcase
        fetch("rnd", (kind != 3), a);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
